// File: rtl/cache_ctrl.sv
// cache_ctrl: 8-set, 4-way write-back/write-allocate cache controller.
// Tags/state live here; line data sits in an external 1-cycle SRAM.
module cache_ctrl #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              da_en,
   output logic              da_we,
   output logic [2:0]        da_set,
   output logic [1:0]        da_way,
   output logic [3:0]        da_word,
   output logic [DATA_W-1:0] da_wdata,
   input  logic [DATA_W-1:0] da_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOOKUP = 3'd1;
   localparam logic [2:0] WB_RD  = 3'd2;
   localparam logic [2:0] WB_MEM = 3'd3;
   localparam logic [2:0] REFILL = 3'd4;
   localparam logic [2:0] RESP   = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [3:0]        word_q, word_d;
   logic [1:0]        vic_q;
   logic              we_q;
   logic [4:0]        tag_q;
   logic [2:0]        set_q;
   logic [3:0]        off_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] wb_q;
   logic              fresh_q;

   logic [4:0] tags_q  [8][4];
   logic       valid_q [8][4];
   logic       dirty_q [8][4];
   logic [1:0] age_q   [8][4];

   logic       hit;
   logic [1:0] hit_way;
   logic [1:0] vic_way;
   logic       last_word;

   assign last_word = (word_q == 4'hF);

   // Tag compare and victim choice for the latched set
   always_comb begin
      hit     = 1'b0;
      hit_way = 2'd0;
      vic_way = 2'd0;
      for (int w = 3; w >= 0; w--) begin
         if (valid_q[set_q][w] && tags_q[set_q][w] == tag_q) begin
            hit     = 1'b1;
            hit_way = 2'(w);
         end
      end
      for (int w = 0; w < 4; w++) begin
         if (age_q[set_q][w] == 2'd3) vic_way = 2'(w);
      end
      for (int w = 3; w >= 0; w--) begin
         if (!valid_q[set_q][w]) vic_way = 2'(w);
      end
   end

   // Next state and all outputs of the controller
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      da_en      = 1'b0;
      da_we      = 1'b0;
      da_set     = '0;
      da_way     = '0;
      da_word    = '0;
      da_wdata   = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      unique case (state_q)
         IDLE: begin
            req_ready = rst_n;
            if (req_valid) state_d = LOOKUP;
         end
         LOOKUP: begin
            if (hit) begin
               da_en    = 1'b1;
               da_we    = we_q;
               da_set   = set_q;
               da_way   = hit_way;
               da_word  = off_q;
               da_wdata = we_q ? wdata_q : '0;
               state_d  = RESP;
            end else if (valid_q[set_q][vic_way] &&
                         dirty_q[set_q][vic_way]) begin
               state_d = WB_RD;
            end else begin
               state_d = REFILL;
            end
         end
         WB_RD: begin
            da_en   = 1'b1;
            da_set  = set_q;
            da_way  = vic_q;
            da_word = word_q;
            state_d = WB_MEM;
         end
         WB_MEM: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {tags_q[set_q][vic_q], set_q, word_q};
            mem_wdata = fresh_q ? da_rdata : wb_q;
            if (mem_ack) begin
               word_d  = word_q + 4'd1;
               state_d = last_word ? REFILL : WB_RD;
            end
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {tag_q, set_q, word_q};
            if (mem_ack) begin
               da_en    = 1'b1;
               da_we    = 1'b1;
               da_set   = set_q;
               da_way   = vic_q;
               da_word  = word_q;
               da_wdata = mem_rdata;
               word_d   = word_q + 4'd1;
               if (last_word) state_d = LOOKUP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_rdata = we_q ? '0 : da_rdata;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers: state, word counter, latched request, WB data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         word_q  <= '0;
         vic_q   <= '0;
         we_q    <= 1'b0;
         tag_q   <= '0;
         set_q   <= '0;
         off_q   <= '0;
         wdata_q <= '0;
         wb_q    <= '0;
         fresh_q <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         fresh_q <= (state_q == WB_RD);
         if (fresh_q) wb_q <= da_rdata;
         if (state_q == IDLE && req_valid) begin
            we_q    <= req_we;
            tag_q   <= req_addr[11:7];
            set_q   <= req_addr[6:4];
            off_q   <= req_addr[3:0];
            wdata_q <= req_wdata;
         end
         if (state_q == LOOKUP && !hit) vic_q <= vic_way;
      end
   end

   // Per-line tag, valid, dirty and LRU age bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 4; w++) begin
               tags_q[s][w]  <= '0;
               valid_q[s][w] <= 1'b0;
               dirty_q[s][w] <= 1'b0;
               age_q[s][w]   <= 2'(w);
            end
         end
      end else begin
         if (state_q == LOOKUP && hit) begin
            for (int w = 0; w < 4; w++) begin
               if (2'(w) == hit_way)
                  age_q[set_q][w] <= 2'd0;
               else if (age_q[set_q][w] < age_q[set_q][hit_way])
                  age_q[set_q][w] <= age_q[set_q][w] + 2'd1;
            end
            if (we_q) dirty_q[set_q][hit_way] <= 1'b1;
         end
         if (state_q == WB_MEM && mem_ack && last_word)
            dirty_q[set_q][vic_q] <= 1'b0;
         if (state_q == REFILL && mem_ack && last_word) begin
            tags_q[set_q][vic_q]  <= tag_q;
            valid_q[set_q][vic_q] <= 1'b1;
            dirty_q[set_q][vic_q] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed checks of cache_ctrl against a flat-memory
// reference with a recency-list LRU model, SRAM and memory models.
`timescale 1ns/1ps
module tb_cache_ctrl;

   typedef struct {
      bit         we;
      logic [11:0] addr;
      logic [15:0] data;
      logic [1:0]  way;
   } xfer_t;

   typedef struct {
      logic [15:0] data;
      bit          hit;
      int          acc;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [11:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        da_en, da_we;
   logic [2:0]  da_set;
   logic [1:0]  da_way;
   logic [3:0]  da_word;
   logic [15:0] da_wdata;
   logic [15:0] da_rdata = '0;
   logic        mem_req, mem_we;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata;

   int checks = 0;
   int fails = 0;
   int edge_n = 0;

   logic [15:0] sram [8][4][16];
   logic [15:0] phys [4096];

   logic [4:0]  mtag [8][4];
   bit          mval [8][4];
   bit          mdirty [8][4];
   int          order [8][4];
   logic [15:0] arch [4096];

   xfer_t xq[$];
   resp_t rq[$];

   int          ack_dly = 0;
   bit          junk_ack = 1'b0;
   int          n_wr, n_rd, n_resp;
   logic [11:0] first_wr, first_rd, last_rd;
   logic [1:0]  last_way;
   logic [15:0] last_rdata;

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   assign mem_rdata = phys[mem_addr];

   cache_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .da_en(da_en), .da_we(da_we), .da_set(da_set),
      .da_way(da_way), .da_word(da_word),
      .da_wdata(da_wdata), .da_rdata(da_rdata),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   // External data SRAM, one-cycle read latency
   always @(posedge clk) begin
      if (da_en) begin
         if (da_we) sram[da_set][da_way][da_word] <= da_wdata;
         else da_rdata <= sram[da_set][da_way][da_word];
      end
   end

   task automatic chk(input string nm, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      fails++;
      $display("FAIL %s", nm);
   endtask

   function automatic void touch(int s, int w);
      int p = 0;
      for (int i = 0; i < 4; i++) if (order[s][i] == w) p = i;
      for (int i = p; i > 0; i--) order[s][i] = order[s][i-1];
      order[s][0] = w;
   endfunction

   function automatic int age_of(int s, int w);
      int a = 0;
      for (int i = 0; i < 4; i++) if (order[s][i] == w) a = i;
      return a;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 8; s++) begin
         for (int w = 0; w < 4; w++) begin
            mval[s][w] = 1'b0;
            mdirty[s][w] = 1'b0;
            mtag[s][w] = '0;
            order[s][w] = w;
         end
      end
      for (int a = 0; a < 4096; a++) arch[a] = phys[a];
   endtask

   // Predict traffic and response from the model, then issue the request
   task automatic do_req(input bit we, input logic [11:0] addr,
                         input logic [15:0] wd, input bit wait_resp);
      logic [4:0]  t;
      logic [2:0]  s;
      logic [11:0] a;
      logic [15:0] expd;
      int          way;
      bit          hit;
      int          k;
      t = addr[11:7];
      s = addr[6:4];
      way = -1;
      for (int w = 0; w < 4; w++)
         if (mval[s][w] && mtag[s][w] == t) way = w;
      hit = (way >= 0);
      if (!hit) begin
         for (int w = 3; w >= 0; w--) if (!mval[s][w]) way = w;
         if (way < 0) way = order[s][3];
         if (mval[s][way] && mdirty[s][way]) begin
            for (int i = 0; i < 16; i++) begin
               a = {mtag[s][way], s, 4'(i)};
               xq.push_back('{1'b1, a, arch[a], 2'(way)});
            end
         end
         for (int i = 0; i < 16; i++)
            xq.push_back('{1'b0, {t, s, 4'(i)}, 16'h0, 2'(way)});
         mtag[s][way] = t;
         mval[s][way] = 1'b1;
         mdirty[s][way] = 1'b0;
      end
      touch(s, way);
      if (we) begin
         arch[addr] = wd;
         mdirty[s][way] = 1'b1;
      end
      expd = we ? 16'h0 : arch[addr];
      n_wr = 0;
      n_rd = 0;
      n_resp = 0;
      @(negedge clk);
      k = 0;
      while (!req_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) fail("ready_timeout");
      req_valid = 1'b1;
      req_we = we;
      req_addr = addr;
      req_wdata = wd;
      @(posedge clk);
      #1;
      rq.push_back('{expd, hit, edge_n});
      req_valid = 1'b0;
      if (wait_resp) begin
         k = 0;
         while (n_resp == 0 && k < 3000) begin
            @(posedge clk);
            k++;
         end
         if (n_resp == 0) fail("resp_timeout");
         chk("xfer_left", xq.size(), 0);
      end
   endtask

   // Memory responder and the per-cycle compare of DUT outputs
   initial begin
      xfer_t       x;
      resp_t       e;
      bit          pend;
      logic [28:0] pend_v;
      int          wcnt;
      pend = 1'b0;
      wcnt = 0;
      for (int a = 0; a < 4096; a++) phys[a] = 16'(a) ^ 16'hA5A5;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_outs",
                {req_ready, resp_valid, resp_rdata, da_en, da_we,
                 da_set, da_way, da_word, da_wdata, mem_req,
                 mem_we, mem_addr, mem_wdata}, '0);
            xq.delete();
            rq.delete();
            pend = 1'b0;
            wcnt = 0;
            mem_ack = 1'b0;
            continue;
         end
         if (resp_valid) begin
            chk("resp_quiet", {da_en, mem_req, req_ready}, 0);
            if (rq.size() == 0) fail("unexp_resp");
            else begin
               e = rq.pop_front();
               chk("resp_data", resp_rdata, e.data);
               if (e.hit) chk("hit_lat", edge_n + 1 - e.acc, 2);
            end
            last_rdata = resp_rdata;
            n_resp++;
         end
         if (mem_req) begin
            if (pend)
               chk("mem_stable", {mem_we, mem_addr, mem_wdata}, pend_v);
            if (wcnt >= ack_dly) begin
               mem_ack = 1'b1;
               wcnt = 0;
               pend = 1'b0;
               if (xq.size() == 0) fail("unexp_xfer");
               else begin
                  x = xq.pop_front();
                  chk("xfer_we", mem_we, x.we);
                  chk("xfer_addr", mem_addr, x.addr);
                  if (x.we) begin
                     chk("xfer_wdata", mem_wdata, x.data);
                     if (n_wr == 0) first_wr = mem_addr;
                     n_wr++;
                     phys[mem_addr] = mem_wdata;
                  end else begin
                     if (n_rd == 0) first_rd = mem_addr;
                     last_rd = mem_addr;
                     n_rd++;
                     #1;
                     chk("refill_da",
                         {da_en, da_we, da_set, da_way, da_word, da_wdata},
                         {2'b11, x.addr[6:4], x.way, x.addr[3:0], mem_rdata});
                     last_way = da_way;
                  end
               end
            end else begin
               mem_ack = 1'b0;
               wcnt++;
               pend = 1'b1;
               pend_v = {mem_we, mem_addr, mem_wdata};
            end
         end else begin
            mem_ack = junk_ack;
            wcnt = 0;
            pend = 1'b0;
         end
      end
   end

   // Directed scenarios
   initial begin
      int k;
      #1;
      model_reset();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      #1 chk("ready_after_rst", req_ready, 1'b1);

      do_req(1'b0, 12'h123, 16'h0, 1'b1);
      chk("r22_nrd", n_rd, 16);
      chk("r22_first", first_rd, 12'h120);
      chk("r22_last", last_rd, 12'h12F);
      chk("r22_data", last_rdata, 16'hA486);
      do_req(1'b0, 12'h123, 16'h0, 1'b1);
      chk("r22_hit_nomem", n_rd + n_wr, 0);
      chk("r22_hit_data", last_rdata, 16'hA486);

      do_req(1'b1, 12'h045, 16'hBEEF, 1'b1);
      chk("r23_wr_resp", last_rdata, 16'h0);
      do_req(1'b0, 12'h045, 16'h0, 1'b1);
      chk("r23_data", last_rdata, 16'hBEEF);
      chk("r23_nomem", n_rd + n_wr, 0);
      do_req(1'b1, 12'h124, 16'h1234, 1'b1);
      do_req(1'b0, 12'h124, 16'h0, 1'b1);
      chk("wr_hit_data", last_rdata, 16'h1234);

      ack_dly = 3;
      junk_ack = 1'b1;
      do_req(1'b1, 12'h000, 16'h0A0A, 1'b1);
      do_req(1'b0, 12'h080, 16'h0, 1'b1);
      do_req(1'b0, 12'h100, 16'h0, 1'b1);
      do_req(1'b0, 12'h180, 16'h0, 1'b1);
      do_req(1'b0, 12'h200, 16'h0, 1'b1);
      chk("r24_nwr", n_wr, 16);
      chk("r24_nrd", n_rd, 16);
      chk("r24_first_wr", first_wr, 12'h000);
      chk("r24_first_rd", first_rd, 12'h200);
      chk("r24_victim", last_way, 2'd0);
      chk("r24_wb0", phys[0], 16'h0A0A);
      chk("r24_wb1", phys[1], 16'hA5A4);
      do_req(1'b0, 12'h000, 16'h0, 1'b1);
      chk("r24_reread", last_rdata, 16'h0A0A);
      junk_ack = 1'b0;

      ack_dly = 0;
      do_req(1'b0, 12'h050, 16'h0, 1'b1);
      do_req(1'b0, 12'h0D0, 16'h0, 1'b1);
      do_req(1'b0, 12'h150, 16'h0, 1'b1);
      do_req(1'b0, 12'h1D0, 16'h0, 1'b1);
      do_req(1'b0, 12'h150, 16'h0, 1'b1);
      do_req(1'b0, 12'h0D0, 16'h0, 1'b1);
      do_req(1'b0, 12'h1D0, 16'h0, 1'b1);
      chk("r27_model_ages",
          {2'(age_of(5, 0)), 2'(age_of(5, 1)),
           2'(age_of(5, 2)), 2'(age_of(5, 3))}, 8'b11_01_10_00);
      do_req(1'b0, 12'h250, 16'h0, 1'b1);
      chk("r27_victim", last_way, 2'd0);

      ack_dly = 3;
      do_req(1'b0, 12'h3A7, 16'h0, 1'b0);
      k = 0;
      do begin
         @(posedge clk);
         #2;
         k++;
      end while (!(mem_req && mem_addr == 12'h3A7) && k < 500);
      if (!(mem_req && mem_addr == 12'h3A7)) fail("r26_no_word7");
      chk("r26_words_done", n_rd, 7);
      rst_n = 1'b0;
      #1;
      chk("r26_abort", {mem_req, resp_valid, req_ready}, 0);
      repeat (2) @(posedge clk);
      model_reset();
      #2 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      chk("r26_no_resp", n_resp, 0);
      ack_dly = 0;
      do_req(1'b0, 12'h3A7, 16'h0, 1'b1);
      chk("r26_refill", n_rd, 16);
      chk("r26_data", last_rdata, 16'hA602);
      do_req(1'b0, 12'h045, 16'h0, 1'b1);
      chk("r26_lost_dirty", last_rdata, 16'hA5E0);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, byte-free word address width; only the default is supported.
REQ-002 SHALL have parameter DATA_W, default 16, word width; only the default is supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have CPU ports:
- req_valid, input, 1
- req_ready, output, 1
- req_we, input, 1
- req_addr, input, 12: tag [11:7], set [6:4], offset [3:0]
- req_wdata, input, 16
- resp_valid, output, 1
- resp_rdata, output, 16
REQ-006 SHALL have data-array ports, for an external 8-set x 4-way x 16-word SRAM with 1-cycle read latency:
- da_en, output, 1
- da_we, output, 1
- da_set, output, 3
- da_way, output, 2
- da_word, output, 4
- da_wdata, output, 16
- da_rdata, input, 16
REQ-007 SHALL have memory ports:
- mem_req, output, 1
- mem_we, output, 1
- mem_addr, output, 12
- mem_wdata, output, 16
- mem_ack, input, 1
- mem_rdata, input, 16

Function
REQ-008 SHALL hold per-set, per-way tag (5 b), valid, dirty and 2-bit LRU age internally; policy is write-back, write-allocate.
REQ-009 SHALL assert req_ready only in IDLE; a request is accepted on clk edge with req_valid&&req_ready and its fields are latched.
REQ-010 SHALL use states IDLE, LOOKUP, WB_RD, WB_MEM, REFILL, RESP.
- IDLE->LOOKUP on accept.
- LOOKUP->RESP on hit.
- LOOKUP->WB_RD on miss with dirty victim.
- LOOKUP->REFILL on miss with clean/invalid victim.
REQ-011 In LOOKUP, hit SHALL be valid && tag match in any way; on hit, da_en=1, da_set/da_way/da_word=latched set/hit way/offset.
- For a write, da_we=1, da_wdata=req_wdata, and dirty is set.
REQ-012 RESP SHALL last one cycle with resp_valid=1; resp_rdata=da_rdata for reads, 0 for writes; then IDLE.
- Read-hit response appears 2 cycles after the accept edge.
REQ-013 Victim SHALL be the lowest-index invalid way, else the way with age 3.
REQ-014 On every hit, the accessed way's age SHALL become 0 and ways with smaller age SHALL increment; other ages are unchanged.
REQ-015 WB SHALL loop word i=0..15:
- WB_RD: da_en=1, da_we=0, word i.
- WB_MEM: mem_req=1, mem_we=1, mem_addr={victim tag,set,i}, mem_wdata=captured da_rdata.
- Hold until mem_ack; after i=15, clear dirty and go to REFILL.
REQ-016 REFILL SHALL, per word i=0..15:
- Hold mem_req=1, mem_we=0, mem_addr={req tag,set,i}.
- In the mem_ack cycle, write mem_rdata to da word i of the victim way.
- After i=15, set tag/valid=1, dirty=0, and return to LOOKUP (replay as hit).
REQ-017 mem_req, mem_addr, mem_wdata SHALL stay stable while waiting for mem_ack.
- mem_ack is ignored when mem_req=0.
- mem_ack in the same cycle mem_req rises completes the word.
REQ-018 Word counter SHALL be 4 bits, wrapping 15->0 at the end of each WB/REFILL phase.
REQ-019 da_en, da_we, mem_req SHALL be 0 in IDLE and RESP.

Reset
REQ-020 rst_n low SHALL immediately force:
- state IDLE
- all valid/dirty 0
- age[way]=way index in every set
- word counter 0
- all outputs 0, except req_ready=1 after release
REQ-021 Reset during WB or REFILL SHALL abort the transfer: mem_req drops at once, no line becomes valid, and no response is issued.

Verification
REQ-022 After reset, read 0x123 -> miss, 16 refill reads at mem_addr 0x120..0x12F, then resp_valid with word 3 of the block; a second read of 0x123 responds 2 cycles after accept.
REQ-023 Write 0xBEEF to 0x045, then read 0x045 -> 0xBEEF from a hit; no memory traffic after the initial refill.
REQ-024 Fill set 0 with tags 0..3 (dirty way 0), then access tag 4 set 0 -> way 0 victim; 16 writes to 0x000..0x00F precede 16 reads from 0x200..0x20F.
REQ-025 With mem_ack delayed 3 cycles per word -> mem_addr/mem_wdata stable across the wait and exactly 16 transfers.
REQ-026 Assert rst_n low mid-REFILL at word 7 -> mem_req=0 immediately; a following read of the same address misses and refills again.
REQ-027 Hits on ways 2,1,3 in set 5 -> ages {3,1,2,0} for ways 0..3 and victim way 0.
